pd_event_tracker: RTL and testbench
===================================

Name: pd_event_tracker

Overview:
- Sits directly downstream of the DSP multiply/pattern-detect stage and consumes its registered one-cycle match flag.
- Groups consecutive match cycles into runs and timestamps each run.
- Runs meeting a programmable length threshold are emitted as event records over a valid/ready interface to the status/interrupt logic.
- Also keeps a saturating total-match count and a sticky overflow flag for event records dropped while the output is occupied.

Parameters:
- LEN_W, 8: width of the run-length counter and of evt_len_o.
- STAMP_W, 16: width of the free-running timestamp and of evt_stamp_o.
- CNT_W, 32: width of the total-match counter total_o.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- en_i  in  1  tracker enable; when low, match_i is treated as 0 and the timestamp holds.
- clear_i  in  1  synchronous clear of all state; highest priority.
- match_i  in  1  pattern-detect flag from the DSP stage, sampled every cycle.
- run_thresh_i  in  LEN_W  minimum run length to report; 0 is treated as 1.
- evt_valid_o  out  1  event record valid.
- evt_ready_i  in  1  consumer accepts the record when evt_valid_o and evt_ready_i are both high.
- evt_len_o  out  LEN_W  run length in cycles, saturated.
- evt_stamp_o  out  STAMP_W  timestamp of the first match cycle of the run.
- total_o  out  CNT_W  total qualified match cycles, saturating.
- overflow_o  out  1  sticky: an event was dropped.

Behaviour:
- Reset (rst_ni low, async): all outputs 0, FSM in IDLE, timestamp 0, run counter 0.
- clear_i high (sync): same state as reset, next edge; overrides every other input that cycle.
- Qualified match: m = en_i & match_i.
- Timestamp: increments by 1 each cycle en_i is high; wraps modulo 2^STAMP_W; no flag on wrap.
- total_o: increments on each cycle m=1; saturates at all-ones.
- Run FSM, two states:
  - IDLE, m=1: go to RUN, run_len=1, start_stamp=current timestamp.
  - IDLE, m=0: stay in IDLE.
  - RUN, m=1: run_len+1, saturating at 2^LEN_W-1.
  - RUN, m=0 (including en_i low): run ends; go to IDLE.
- Qualification: a run that ends with run_len >= max(run_thresh_i, 1) produces an event; shorter runs are discarded silently. run_thresh_i is sampled in the cycle the run ends.
- Latency: the run ends when m=0 is sampled at edge t. The record is visible with evt_valid_o=1 after edge t+1, i.e. one register stage.
- Output buffer: single entry.
  - evt_len_o/evt_stamp_o stay stable while evt_valid_o=1 and no handshake.
  - evt_valid_o drops the cycle after a handshake unless a new event loads that same cycle.
- Simultaneous handshake and new event: the new record loads and evt_valid_o stays 1; no drop.
- New event while buffer full and evt_ready_i=0: the new event is dropped, overflow_o is set, and the held record is unchanged. overflow_o stays set until clear_i or reset.
- Back-to-back runs (pattern 1,0,1) form two separate runs. The second run's start cycle coincides with the first run's end-detection cycle, and both paths must operate in that same cycle.
- Reset mid-run: the run is discarded and nothing is emitted.
- The block applies no synchronization to match_i; it is registered by the upstream stage in the same clk_i domain.

Decomposition:
- Shared package pd_pkg holds:
  - default widths LEN_W/STAMP_W/CNT_W;
  - the run FSM state enum (PD_IDLE, PD_RUN);
  - a packed event record typedef pd_evt_t {len, stamp}, so the upstream DSP stage and downstream consumers share one definition.
- One sub-module is natural: pd_evt_buf, the single-entry valid/ready holding register with the drop/overflow logic. Run tracking, counters and the timestamp stay in the top module.

Test Plan:
- Reset: assert rst_ni=0 asynchronously mid-cycle -> all outputs 0 immediately; after release with en_i=1, timestamp counts 0,1,2...
- Single run: thresh=3, timestamp=10, match_i high 4 cycles then low -> one cycle later evt_valid_o=1, evt_len_o=4, evt_stamp_o=10, total_o=4.
- Below threshold: thresh=5, run of 4 -> no evt_valid_o; total_o still increments by 4.
- Backpressure: evt_ready_i=0, two qualifying runs (1,0,1 with thresh=1) -> first record held, overflow_o=1, second lost. Then raise evt_ready_i -> one handshake, evt_valid_o falls.
- Same-cycle accept+load: handshake in the cycle a new run qualifies -> evt_valid_o stays 1 with the new len/stamp, overflow_o=0.
- Saturation/wrap/clear: LEN_W=4, run of 20 -> evt_len_o=15. STAMP_W=4, timestamp wraps 15->0. clear_i mid-run -> no event, total_o=0, overflow_o=0.

Source files
------------

// File: rtl/pd_pkg.sv
// pd_pkg: shared widths, run FSM states and event record layout for the pattern-detect tracker.
package pd_pkg;
    localparam int LEN_W   = 8;
    localparam int STAMP_W = 16;
    localparam int CNT_W   = 32;

    typedef enum logic {PD_IDLE, PD_RUN} pd_state_e;

    typedef struct packed {
        logic [LEN_W-1:0]   len;
        logic [STAMP_W-1:0] stamp;
    } pd_evt_t;
endpackage

// File: rtl/pd_evt_buf.sv
// pd_evt_buf: single-entry valid/ready holding register; drops and flags records arriving while full.
module pd_evt_buf import pd_pkg::*; #(
    parameter int W = $bits(pd_evt_t)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         overflow
);
    logic load;

    // a handshake frees the slot in the same cycle, so accept-and-reload never drops
    always_comb load = in_valid & (~valid | ready);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid    <= 1'b0;
            data     <= '0;
            overflow <= 1'b0;
        end else if (clear_i) begin
            valid    <= 1'b0;
            data     <= '0;
            overflow <= 1'b0;
        end else begin
            valid    <= load ? 1'b1 : (valid & ~ready);
            overflow <= overflow | (in_valid & valid & ~ready);
            if (load) data <= in_data;
        end
    end
endmodule

// File: rtl/pd_event_tracker.sv
// pd_event_tracker: groups qualified match cycles into timestamped runs and reports runs meeting a length threshold.
module pd_event_tracker import pd_pkg::*; #(
    parameter int LEN_W   = pd_pkg::LEN_W,
    parameter int STAMP_W = pd_pkg::STAMP_W,
    parameter int CNT_W   = pd_pkg::CNT_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    input  logic               clear_i,
    input  logic               match_i,
    input  logic [LEN_W-1:0]   run_thresh_i,
    output logic               evt_valid_o,
    input  logic               evt_ready_i,
    output logic [LEN_W-1:0]   evt_len_o,
    output logic [STAMP_W-1:0] evt_stamp_o,
    output logic [CNT_W-1:0]   total_o,
    output logic               overflow_o
);
    localparam int EW = LEN_W + STAMP_W;

    pd_state_e          state_q, state_d;
    logic [STAMP_W-1:0] stamp_q, start_q;
    logic [LEN_W-1:0]   len_q, len_d, thr;
    logic [CNT_W-1:0]   total_q;
    logic               m, qualify, pend_v_q;
    logic [EW-1:0]      pend_q, evt_data;

    always_comb begin
        m       = en_i & match_i;
        state_d = m ? PD_RUN : PD_IDLE;
        len_d   = (state_q == PD_IDLE) ? LEN_W'(1) : (&len_q ? len_q : len_q + 1'b1);
        thr     = (run_thresh_i == '0) ? LEN_W'(1) : run_thresh_i;
        qualify = (state_q == PD_RUN) && !m && (len_q >= thr);
    end

    // the finished run is staged one cycle so a new run can start while the old one is emitted
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= PD_IDLE;
            stamp_q  <= '0;
            start_q  <= '0;
            len_q    <= '0;
            total_q  <= '0;
            pend_v_q <= 1'b0;
            pend_q   <= '0;
        end else if (clear_i) begin
            state_q  <= PD_IDLE;
            stamp_q  <= '0;
            start_q  <= '0;
            len_q    <= '0;
            total_q  <= '0;
            pend_v_q <= 1'b0;
            pend_q   <= '0;
        end else begin
            state_q  <= state_d;
            pend_v_q <= qualify;
            if (en_i) stamp_q <= stamp_q + 1'b1;
            if (m) len_q <= len_d;
            if (m && state_q == PD_IDLE) start_q <= stamp_q;
            if (m && !(&total_q)) total_q <= total_q + 1'b1;
            if (qualify) pend_q <= {len_q, start_q};
        end
    end

    pd_evt_buf #(.W(EW)) u_buf (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (clear_i),
        .in_valid (pend_v_q),
        .in_data  (pend_q),
        .ready    (evt_ready_i),
        .valid    (evt_valid_o),
        .data     (evt_data),
        .overflow (overflow_o)
    );

    assign {evt_len_o, evt_stamp_o} = evt_data;
    assign total_o = total_q;
endmodule

// File: tb/tb_pd_event_tracker.sv
// tb_pd_event_tracker: directed and random stimulus against a run/event reference model.
module tb_pd_event_tracker;
    localparam int LEN_W   = 4;
    localparam int STAMP_W = 4;
    localparam int CNT_W   = 10;
    localparam int LEN_MAX = (1 << LEN_W) - 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk_i = 1'b0;
    logic               rst_ni = 1'b0;
    logic               en_i = 1'b0;
    logic               clear_i = 1'b0;
    logic               match_i = 1'b0;
    logic [LEN_W-1:0]   run_thresh_i = '0;
    logic               evt_valid_o;
    logic               evt_ready_i = 1'b0;
    logic [LEN_W-1:0]   evt_len_o;
    logic [STAMP_W-1:0] evt_stamp_o;
    logic [CNT_W-1:0]   total_o;
    logic               overflow_o;

    pd_event_tracker #(.LEN_W(LEN_W), .STAMP_W(STAMP_W), .CNT_W(CNT_W)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .en_i         (en_i),
        .clear_i      (clear_i),
        .match_i      (match_i),
        .run_thresh_i (run_thresh_i),
        .evt_valid_o  (evt_valid_o),
        .evt_ready_i  (evt_ready_i),
        .evt_len_o    (evt_len_o),
        .evt_stamp_o  (evt_stamp_o),
        .total_o      (total_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {int len; int stamp; int due;} ev_t;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int ts, total, run_len, run_start;
    bit in_run, b_v, b_ovf;
    int b_len, b_stamp;
    ev_t pend[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        ts = 0; total = 0; run_len = 0; run_start = 0; in_run = 0;
        b_v = 0; b_ovf = 0; b_len = 0; b_stamp = 0;
        pend.delete();
    endtask

    // one clock edge of the reference: finished runs surface in the output slot one cycle after they end
    task automatic model_edge();
        bit m;
        int thr;
        if (clear_i) begin
            model_reset();
        end else begin
            m = en_i & match_i;
            thr = (run_thresh_i == 0) ? 1 : int'(run_thresh_i);
            if (b_v && evt_ready_i) b_v = 0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                if (b_v) b_ovf = 1;
                else begin
                    b_v = 1; b_len = pend[0].len; b_stamp = pend[0].stamp;
                end
                void'(pend.pop_front());
            end
            if (m) begin
                if (!in_run) begin in_run = 1; run_start = ts; run_len = 0; end
                run_len++;
            end else if (in_run) begin
                in_run = 0;
                if (run_len >= thr)
                    pend.push_back('{(run_len > LEN_MAX) ? LEN_MAX : run_len, run_start, cyc + 1});
            end
            if (m && total < CNT_MAX) total++;
            if (en_i) ts = (ts + 1) % (1 << STAMP_W);
        end
        cyc++;
    endtask

    task automatic compare_all();
        check("valid", 32'(evt_valid_o), 32'(b_v));
        check("len", 32'(evt_len_o), 32'(b_len));
        check("stamp", 32'(evt_stamp_o), 32'(b_stamp));
        check("total", 32'(total_o), 32'(total));
        check("overflow", 32'(overflow_o), 32'(b_ovf));
    endtask

    task automatic step(input bit en, input bit mt, input int thr, input bit rdy, input bit clr);
        en_i = en; match_i = mt; run_thresh_i = LEN_W'(thr); evt_ready_i = rdy; clear_i = clr;
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
        compare_all();
    endtask

    task automatic async_reset();
        #2 rst_ni = 1'b0;
        #1;
        model_reset();
        check("rst_valid", 32'(evt_valid_o), 32'd0);
        check("rst_len", 32'(evt_len_o), 32'd0);
        check("rst_stamp", 32'(evt_stamp_o), 32'd0);
        check("rst_total", 32'(total_o), 32'd0);
        check("rst_overflow", 32'(overflow_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk_i);
        async_reset();
        // single qualifying run starting at timestamp 10
        repeat (10) step(1, 0, 3, 1, 0);
        repeat (4) step(1, 1, 3, 1, 0);
        step(1, 0, 3, 1, 0);
        check("single_not_yet", 32'(evt_valid_o), 32'd0);
        step(1, 0, 3, 1, 0);
        check("single_valid", 32'(evt_valid_o), 32'd1);
        check("single_len", 32'(evt_len_o), 32'd4);
        check("single_stamp", 32'(evt_stamp_o), 32'd10);
        check("single_total", 32'(total_o), 32'd4);
        step(1, 0, 3, 1, 0);
        // run shorter than threshold
        repeat (4) step(1, 1, 5, 1, 0);
        repeat (3) begin
            step(1, 0, 5, 1, 0);
            check("below_valid", 32'(evt_valid_o), 32'd0);
        end
        check("below_total", 32'(total_o), 32'd8);
        // backpressure: 1,0,1 forms two runs, second is dropped
        step(1, 1, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        repeat (3) step(1, 0, 1, 0, 0);
        check("bp_valid", 32'(evt_valid_o), 32'd1);
        check("bp_len", 32'(evt_len_o), 32'd1);
        check("bp_overflow", 32'(overflow_o), 32'd1);
        step(1, 0, 1, 1, 0);
        check("bp_drained", 32'(evt_valid_o), 32'd0);
        step(1, 0, 1, 0, 0);
        // same-cycle accept and load
        step(1, 0, 1, 0, 1);
        step(1, 1, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 1, 0);
        check("swap_valid", 32'(evt_valid_o), 32'd1);
        check("swap_len", 32'(evt_len_o), 32'd2);
        check("swap_overflow", 32'(overflow_o), 32'd0);
        step(1, 0, 1, 1, 0);
        // run length saturation across a timestamp wrap
        repeat (20) step(1, 1, 1, 1, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        check("sat_len", 32'(evt_len_o), 32'(LEN_MAX));
        step(1, 0, 1, 1, 0);
        // clear mid-run
        repeat (3) step(1, 1, 1, 1, 0);
        step(1, 1, 1, 1, 1);
        repeat (3) step(1, 0, 1, 1, 0);
        check("clr_valid", 32'(evt_valid_o), 32'd0);
        check("clr_total", 32'(total_o), 32'd0);
        // reset mid-run
        repeat (3) step(1, 1, 1, 1, 0);
        async_reset();
        repeat (3) step(1, 0, 1, 1, 0);
        check("rstrun_valid", 32'(evt_valid_o), 32'd0);
        // total saturation
        repeat (CNT_MAX + 20) step(1, 1, 1, 1, 0);
        check("total_sat", 32'(total_o), 32'(CNT_MAX));
        step(1, 0, 1, 1, 0);
        // random traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 7) != 0, $urandom_range(0, 9) < 6, int'($urandom_range(0, 5)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 299) == 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
